// File: rtl/text_buf_writer_pkg.sv
// text_pkg: geometry, control codes and encodings shared by the text writer,
// its cursor, and the pixel generator on the video side of the tile RAM.
package text_pkg;

  // Screen geometry in character tiles.
  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned COL_W = 7;   // 2**COL_W >= COLS
  localparam int unsigned ROW_W = 5;   // 2**ROW_W >= ROWS

  // Fill code used by clear-screen and backspace.
  localparam logic [6:0] BLANK = 7'h20;

  // Control codes interpreted by the writer.
  localparam logic [6:0] ASCII_BS = 7'h08;
  localparam logic [6:0] ASCII_LF = 7'h0A;
  localparam logic [6:0] ASCII_FF = 7'h0C;
  localparam logic [6:0] ASCII_CR = 7'h0D;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // Cursor update requests issued to text_cursor.
  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_INC,   // advance one column, wrapping into the next row
    CUR_DEC,   // back one column, never leaves the row
    CUR_CR,    // column 0, same row
    CUR_LF,    // column 0, next row
    CUR_HOME   // (0,0)
  } cur_cmd_e;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_buf_writer_if.sv
// text_buf_writer_if: character stream from the source plus the tile RAM
// write port driven by the writer.
//   char_in/char_valid/char_ready : valid/ready character handshake
//   wr_en/wr_addr/wr_data         : tile RAM write port, address {row, col}
// slave  = writer side, master = source / RAM side.
interface text_buf_writer_if
  import text_pkg::*;
#(
  parameter int unsigned AW = ROW_W + COL_W
);
  logic [6:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;

  modport master (
    output char_in, char_valid,
    input  char_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_buf_writer_cursor.sv
// text_cursor: cursor column/row registers with increment, decrement,
// carriage return, line feed and home. Rows wrap ROWS-1 -> 0 (no scrolling).
//   clk, reset : clock, asynchronous active-high reset
//   cmd        : update request for this cycle
//   cur_x      : cursor column
//   cur_y      : cursor row
module text_cursor
  import text_pkg::*;
#(
  parameter int unsigned COLS  = text_pkg::COLS,
  parameter int unsigned ROWS  = text_pkg::ROWS,
  parameter int unsigned COL_W = text_pkg::COL_W,
  parameter int unsigned ROW_W = text_pkg::ROW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  cur_cmd_e         cmd,
  output logic [COL_W-1:0] cur_x,
  output logic [ROW_W-1:0] cur_y
);

  logic             col_last;
  logic [ROW_W-1:0] row_next;

  // Terminal counts compare against the geometry, not counter overflow.
  assign col_last = (cur_x == COL_W'(COLS - 1));
  assign row_next = (cur_y == ROW_W'(ROWS - 1)) ? '0 : cur_y + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      unique case (cmd)
        CUR_INC: begin
          if (col_last) begin
            cur_x <= '0;
            cur_y <= row_next;
          end else begin
            cur_x <= cur_x + 1'b1;
          end
        end
        CUR_DEC: begin
          if (cur_x != '0) cur_x <= cur_x - 1'b1;
        end
        CUR_CR: cur_x <= '0;
        CUR_LF: begin
          cur_x <= '0;
          cur_y <= row_next;
        end
        CUR_HOME: begin
          cur_x <= '0;
          cur_y <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_buf_writer.sv
// text_buf_writer: writes a stream of 7-bit ASCII characters into the tile
// RAM at the cursor, interprets CR/LF/BS/FF, and runs a full-screen clear.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : character handshake in, tile RAM write port out (registered)
//   clr_req    : single-cycle clear-screen request
//   cur_x/cur_y: cursor column/row
//   busy       : clear sequence in progress
module text_buf_writer
  import text_pkg::*;
#(
  parameter int unsigned COLS  = text_pkg::COLS,
  parameter int unsigned ROWS  = text_pkg::ROWS,
  parameter int unsigned COL_W = text_pkg::COL_W,
  parameter int unsigned ROW_W = text_pkg::ROW_W,
  parameter logic [6:0]  BLANK = text_pkg::BLANK
) (
  input  logic             clk,
  input  logic             reset,
  text_buf_writer_if.slave bus,
  input  logic             clr_req,
  output logic [COL_W-1:0] cur_x,
  output logic [ROW_W-1:0] cur_y,
  output logic             busy
);

  localparam int unsigned AW = ROW_W + COL_W;

  state_e           state, next_state;
  logic [COL_W-1:0] clr_col;
  logic [ROW_W-1:0] clr_row;
  logic             clr_last;

  logic             char_ready;
  logic             accept;

  logic             wr_en_d, wr_en_q;
  logic [AW-1:0]    wr_addr_d, wr_addr_q;
  logic [6:0]       wr_data_d, wr_data_q;
  logic             busy_d;
  logic [COL_W-1:0] col_m1;
  cur_cmd_e         cur_cmd;

  assign char_ready = (state == ST_IDLE) & ~clr_req & ~reset;
  assign accept     = bus.char_valid & char_ready;
  assign clr_last   = (clr_row == ROW_W'(ROWS - 1)) && (clr_col == COL_W'(COLS - 1));
  assign col_m1     = cur_x - 1'b1;

  assign bus.char_ready = char_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

  text_cursor #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .cmd   (cur_cmd),
    .cur_x (cur_x),
    .cur_y (cur_y)
  );

  // State, clear counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      clr_col   <= '0;
      clr_row   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy      <= 1'b0;
    end else begin
      state   <= next_state;
      wr_en_q <= wr_en_d;
      busy    <= busy_d;
      if (wr_en_d) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
      end
      // Counters sit at (0,0) outside CLEAR so every sweep starts at the origin.
      if (state == ST_CLEAR && !clr_last) begin
        if (clr_col == COL_W'(COLS - 1)) begin
          clr_col <= '0;
          clr_row <= clr_row + 1'b1;
        end else begin
          clr_col <= clr_col + 1'b1;
        end
      end else begin
        clr_col <= '0;
        clr_row <= '0;
      end
    end
  end

  // Next state. clr_req is only looked at in IDLE, so it cannot restart a sweep.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (clr_req || (accept && bus.char_in == ASCII_FF)) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_last) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Write request and cursor command for this cycle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    cur_cmd   = CUR_HOLD;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(bus.char_in)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cur_y, cur_x};
            wr_data_d = bus.char_in;
            cur_cmd   = CUR_INC;
          end else begin
            case (bus.char_in)
              ASCII_CR: cur_cmd = CUR_CR;
              ASCII_LF: cur_cmd = CUR_LF;
              ASCII_BS: begin
                if (cur_x != '0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {cur_y, col_m1};
                  wr_data_d = BLANK;
                  cur_cmd   = CUR_DEC;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {clr_row, clr_col};
        wr_data_d = BLANK;
        if (clr_last) cur_cmd = CUR_HOME;
      end
      default: ;
    endcase
  end

  // Registered busy spans the sweep including the cycle carrying the last
  // write, so it falls together with the final wr_en pulse.
  always_comb begin
    busy_d = (state == ST_CLEAR) || (next_state == ST_CLEAR);
  end

endmodule

// File: doc/text_buf_writer.md
Name: text_buf_writer

Overview:
- Writer end of the text display path: accepts a stream of 7-bit ASCII characters and writes them into the dual-port tile RAM.
- The font/text pixel generator reads that same RAM on its video side.
- Maintains a cursor and interprets a small set of control codes.
- Provides a hardware clear-screen sequence.
- Sits between a character source (UART rx, keyboard decoder) and the tile RAM write port.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, character rows.
- COL_W, 7, cursor column width; must satisfy 2^COL_W >= COLS.
- ROW_W, 5, cursor row width; must satisfy 2^ROW_W >= ROWS.
- BLANK, 7'h20, fill code written by clear and backspace.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- char_in  in  7  ASCII code offered by the source.
- char_valid  in  1  char_in is valid this cycle.
- char_ready  out  1  writer can accept a character this cycle.
- clr_req  in  1  single-cycle pulse that requests a clear screen.
- wr_en  out  1  tile RAM write strobe.
- wr_addr  out  ROW_W+COL_W  tile RAM address, {row, col}.
- wr_data  out  7  tile RAM write data.
- cur_x  out  COL_W  cursor column.
- cur_y  out  ROW_W  cursor row.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset: all outputs 0 and state IDLE. Tile RAM contents are not touched.
- Handshake: char_ready = (state==IDLE) & ~clr_req. A character transfers on a cycle where char_valid & char_ready.
- Write timing: wr_en, wr_addr and wr_data are registered and appear on the cycle after the transfer. wr_en is a one-cycle pulse per write.
- The cursor update is visible on cur_x/cur_y on that same following cycle.
- Printable code 0x20..0x7E:
  - Write the code at {cur_y, cur_x}.
  - If cur_x < COLS-1: cur_x+1.
  - Else: cur_x=0 and cur_y advances.
- Row advance: cur_y+1, wrapping from ROWS-1 to 0. No scrolling.
- 0x0D (CR): cur_x=0, no write.
- 0x0A (LF): cur_x=0, row advance, no write.
- 0x08 (BS):
  - If cur_x>0: cur_x-1 and write BLANK at the new position.
  - If cur_x==0: no move, no write. No reverse row wrap.
- 0x0C (FF): consumed and enters CLEAR, identical to clr_req.
- Any other code: consumed and ignored, no write, cursor unchanged.
- FSM states:
  - IDLE: handshake active.
  - CLEAR: busy=1, char_ready=0. Per cycle it writes BLANK at {clr_row, clr_col}, sweeping col 0..COLS-1 within row 0..ROWS-1. Addresses col >= COLS are never emitted. Exactly COLS*ROWS write cycles (2400 at default).
  - After the last write: cursor = (0,0) and return to IDLE. busy deasserts on the cycle after the last wr_en.
- Entry to CLEAR:
  - clr_req in IDLE enters CLEAR on the next edge.
  - clr_req together with char_valid: clear wins and the character is not accepted (ready was 0).
  - clr_req during CLEAR is ignored; it neither restarts nor extends the sequence.
- Reset during CLEAR: immediate abort, all outputs 0, state IDLE. RAM is left partially cleared.
- Widths: the row/col counters are exactly ROW_W/COL_W wide. Terminal-count compares use COLS-1 and ROWS-1, not counter overflow.

Decomposition:
- Shared package (text_pkg): COLS, ROWS, COL_W, ROW_W, BLANK, the control-code constants (ASCII_BS, ASCII_LF, ASCII_CR, ASCII_FF) and the FSM state encoding.
- The pixel generator reuses the same geometry constants.
- One natural sub-module: text_cursor. It holds the cursor registers and inc/dec/home/row-advance with wrap, and is reused by a future scroll variant.
- The clear counters stay in the top-level FSM.

Test Plan:
- Reset, then send 'A' (0x41) -> wr_en one cycle later, wr_addr={0,0}, wr_data=0x41, cur_x=1. char_ready stays high throughout.
- Set cursor to (79,29) by streaming 2399 printables, then send 'Z' -> write at {29,79}, cursor wraps to (0,0). Send 0x0A at (5,3) -> cursor (0,4), no wr_en.
- At (0,2) send 0x08 -> no write, cursor unchanged. At (10,2) send 0x08 -> write BLANK at {2,9}, cursor (9,2).
- Pulse clr_req with char_valid=1 on the same cycle -> char not accepted. busy high, exactly 2400 wr_en pulses, each with wr_data=0x20. No address has col>79. Then cursor (0,0), char_ready=1.
- Send 0x0C -> same clear sequence as clr_req. Send 0x07 -> consumed, no wr_en, cursor unchanged.
- Assert reset asynchronously mid-clear (after 1000 writes) -> wr_en, busy, cur_x and cur_y drop to 0 immediately. After release: IDLE and char_ready=1.
